systolic_sched: RTL

SYSTOLIC_SCHED -- requirements
Module: systolic_sched

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/sched_pix_counter.sv | 45 ++++
 rtl/systolic_sched.sv | 109 ++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic tile scheduler.
// Holds the FSM state encoding and the index width rule.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // An index into a range of one entry still needs one bit.
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sched_pix_counter.sv
// Pixel/slice position counter for the streaming phase.
// Pixel wraps into the slice count; last flags the final pixel of a tile.
module sched_pix_counter
    import systolic_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32,
    parameter int PW     = clog2_min1(WIDTH),
    parameter int SW     = clog2_min1(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    output logic [PW-1:0] pixel_idx,
    output logic [SW-1:0] slice_idx,
    output logic          last
);

    logic pix_end;
    logic slc_end;

    assign pix_end = (pixel_idx == PW'(WIDTH - 1));
    assign slc_end = (slice_idx == SW'(HEIGHT - 1));
    assign last    = pix_end && slc_end;

    // Advance one pixel per enabled cycle, rolling into the next slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_idx <= '0;
            slice_idx <= '0;
        end else if (clear) begin
            pixel_idx <= '0;
            slice_idx <= '0;
        end else if (en) begin
            if (pix_end) begin
                pixel_idx <= '0;
                slice_idx <= slc_end ? '0 : slice_idx + SW'(1);
            end else begin
                pixel_idx <= pixel_idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_sched.sv
// Tile scheduler for a weight-stationary systolic array:
// load weights, stream pixels, drain partial sums, signal done.
module systolic_sched
    import systolic_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int HEIGHT    = 32,
    parameter int ARRAY_DIM = 8,
    localparam int AW = clog2_min1(ARRAY_DIM),
    localparam int PW = clog2_min1(WIDTH),
    localparam int SW = clog2_min1(HEIGHT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          src_valid,
    output logic          busy,
    output logic          done,
    output logic          w_load,
    output logic [AW-1:0] w_row,
    output logic          feed_en,
    output logic [PW-1:0] pixel_idx,
    output logic [SW-1:0] slice_idx,
    output logic          acc_clear,
    output logic          drain
);

    // Drain runs 2*ARRAY_DIM-1 cycles, so the count stays below 2*ARRAY_DIM.
    localparam int DW = clog2_min1(2 * ARRAY_DIM);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] wcnt_q;
    logic [DW-1:0] dcnt_q;
    logic          w_last;
    logic          d_last;
    logic          tile_last;

    assign w_last = (wcnt_q == AW'(ARRAY_DIM - 1));
    assign d_last = (dcnt_q == DW'(2 * ARRAY_DIM - 2));

    assign busy      = (state_q == ST_LOAD_W) || (state_q == ST_STREAM)
                    || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign w_load    = (state_q == ST_LOAD_W);
    assign w_row     = wcnt_q;
    assign feed_en   = (state_q == ST_STREAM) && src_valid;
    assign acc_clear = feed_en && (pixel_idx == '0);
    assign drain     = (state_q == ST_DRAIN);

    sched_pix_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .PW    (PW),
        .SW    (SW)
    ) u_pix (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (abort),
        .en       (feed_en),
        .pixel_idx(pixel_idx),
        .slice_idx(slice_idx),
        .last     (tile_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD_W;
            ST_LOAD_W: if (w_last) state_d = ST_STREAM;
            ST_STREAM: if (feed_en && tile_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (d_last) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    // Weight-row and drain counters run only while their state persists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            dcnt_q <= '0;
        end else begin
            if (state_q == ST_LOAD_W && state_d == ST_LOAD_W) begin
                wcnt_q <= wcnt_q + AW'(1);
            end else begin
                wcnt_q <= '0;
            end
            if (state_q == ST_DRAIN && state_d == ST_DRAIN) begin
                dcnt_q <= dcnt_q + DW'(1);
            end else begin
                dcnt_q <= '0;
            end
        end
    end

endmodule
